mem_bus_ctrl: RTL and testbench



---
 rtl/mem_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns single-cycle MemIO commands into req/ready
// transactions with a bounded wait, and forwards register-write commands
// to the general register file as a one-cycle strobe.
module mem_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        MemIO,
    input  logic [ADDR_W-1:0] ALUAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ValidMemData,
    output logic [DATA_W-1:0] RdData,
    output logic              BusErr,
    output logic              Busy,
    output logic              CmdDropped,
    output logic              GprWe,
    output logic [DATA_W-1:0] GprData
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    // Counter value at which one more unanswered request cycle means abort.
    localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              drop_q;
    logic              gpr_we_q;
    logic [DATA_W-1:0] gpr_data_q;
    logic              is_rw;
    logic              is_gpr;

    assign is_rw  = (MemIO == 2'b01) || (MemIO == 2'b10);
    assign is_gpr = (MemIO == 2'b11);

    // Next-state logic for the bus transaction FSM and its latched operands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (is_rw) begin
                    we_d    = MemIO[1];
                    addr_d  = ALUAddr;
                    wdata_d = WrData;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Ready wins over timeout on the same edge.
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StDone;
                end else if (cnt_q == LastCnt) begin
                    cnt_d   = cnt_q + 8'd1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Drop pulse and register-file strobe, independent of the bus FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q     <= 1'b0;
            gpr_we_q   <= 1'b0;
            gpr_data_q <= '0;
        end else begin
            drop_q   <= is_rw && (state_q != StIdle);
            gpr_we_q <= is_gpr;
            if (is_gpr) begin
                gpr_data_q <= WrData;
            end
        end
    end

    assign mem_req      = (state_q == StReq);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign ValidMemData = (state_q == StDone);
    assign BusErr       = (state_q == StDone) && err_q;
    assign RdData       = rdata_q;
    assign Busy         = (state_q != StIdle);
    assign CmdDropped   = drop_q;
    assign GprWe        = gpr_we_q;
    assign GprData      = gpr_data_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: table-driven transactions, random
// transactions with command noise against a transaction-level model, and
// hand-written collision and reset sequences.
module tb_mem_bus_ctrl;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  MemIO;
    logic [31:0] ALUAddr, WrData, mem_rdata;
    logic        mem_ready;
    logic        mem_req, mem_we, ValidMemData, BusErr, Busy, CmdDropped, GprWe;
    logic [31:0] mem_addr, mem_wdata, RdData, GprData;

    int checks = 0;
    int errors = 0;

    mem_bus_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemIO       (MemIO),
        .ALUAddr     (ALUAddr),
        .WrData      (WrData),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ValidMemData(ValidMemData),
        .RdData      (RdData),
        .BusErr      (BusErr),
        .Busy        (Busy),
        .CmdDropped  (CmdDropped),
        .GprWe       (GprWe),
        .GprData     (GprData)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle: a read/write seen while busy must be dropped, and a
    // register command must strobe GprWe with its data one cycle later.
    bit   chk_en  = 1'b0;
    logic pv_busy = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_dropped", 32'(CmdDropped),
                  32'(pv_busy && (MemIO == 2'b01 || MemIO == 2'b10)));
            check("gpr_we", 32'(GprWe), 32'(MemIO == 2'b11));
            if (MemIO == 2'b11) check("gpr_data", GprData, WrData);
        end
        pv_busy <= Busy;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "/mem_req"}, 32'(mem_req), 0);
        check({tag, "/mem_we"}, 32'(mem_we), 0);
        check({tag, "/mem_addr"}, mem_addr, 0);
        check({tag, "/mem_wdata"}, mem_wdata, 0);
        check({tag, "/valid"}, 32'(ValidMemData), 0);
        check({tag, "/rddata"}, RdData, 0);
        check({tag, "/buserr"}, 32'(BusErr), 0);
        check({tag, "/busy"}, 32'(Busy), 0);
        check({tag, "/dropped"}, 32'(CmdDropped), 0);
        check({tag, "/gpr_we"}, 32'(GprWe), 0);
        check({tag, "/gpr_data"}, GprData, 0);
    endtask

    // Issue one read/write; memory answers on request cycle waits+1.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                           input bit noise, input int exp_req, input int exp_busy,
                           input logic exp_err, input logic [31:0] exp_rd);
        int   req_n, busy_n;
        bit   seen, attr_ok;
        logic err_s;
        logic [31:0] rd_s;
        req_n = 0; busy_n = 0; seen = 0; attr_ok = 1; err_s = 0; rd_s = 0;
        @(negedge clk); #1;
        MemIO     = wr ? 2'b10 : 2'b01;
        ALUAddr   = addr;
        WrData    = wdata;
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        for (int k = 1; k <= int'(TIMEOUT) + 4 && !seen; k++) begin
            @(negedge clk);
            if (Busy) busy_n++;
            if (ValidMemData) begin
                seen  = 1;
                err_s = BusErr;
                rd_s  = RdData;
            end
            if (mem_req) begin
                req_n++;
                if (mem_we !== wr || mem_addr !== addr || (wr && mem_wdata !== wdata))
                    attr_ok = 0;
            end
            #1;
            mem_ready = (k == waits + 1);
            mem_rdata = mem_ready ? rdata : $urandom;
            if (noise && Busy) begin
                MemIO  = 2'($urandom_range(0, 3));
                WrData = $urandom;
            end else begin
                MemIO = 2'b00;
            end
        end
        check({name, "/valid_seen"}, 32'(seen), 1);
        check({name, "/req_cycles"}, req_n, exp_req);
        check({name, "/busy_cycles"}, busy_n, exp_busy);
        check({name, "/buserr"}, 32'(err_s), 32'(exp_err));
        check({name, "/rddata"}, rd_s, exp_rd);
        check({name, "/attrs"}, 32'(attr_ok), 1);
        @(negedge clk);
        check({name, "/idle"}, 32'(Busy), 0);
        check({name, "/rd_hold"}, RdData, exp_rd);
        #1;
        MemIO     = 2'b00;
        mem_ready = 1'b0;
        @(negedge clk);
        check({name, "/no_reissue"}, 32'(mem_req), 0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          exp_req;
        int          exp_busy;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] model_rd;

    initial begin
        tbl[0] = '{1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 0, 1, 2, 1'b0, 32'hCAFEF00D};
        tbl[1] = '{1'b1, 32'h20, 32'h12345678, 32'hDEAD0000, 3, 4, 5, 1'b0, 32'hCAFEF00D};
        tbl[2] = '{1'b0, 32'h44, 32'h0, 32'h11112222, 20, 15, 16, 1'b1, 32'h0};
        tbl[3] = '{1'b0, 32'h48, 32'h0, 32'h5A5A1234, 14, 15, 16, 1'b0, 32'h5A5A1234};
        tbl[4] = '{1'b1, 32'h4C, 32'h0F0F0F0F, 32'h77777777, 15, 15, 16, 1'b1, 32'h0};
        tbl[5] = '{1'b0, 32'h50, 32'h0, 32'h00000001, 13, 14, 15, 1'b0, 32'h00000001};

        rst_n = 1'b0; MemIO = 2'b00; ALUAddr = 0; WrData = 0; mem_ready = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 chk_en = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                    tbl[i].waits, 1'b0, tbl[i].exp_req, tbl[i].exp_busy, tbl[i].exp_err,
                    tbl[i].exp_rd);
        end
        model_rd = tbl[5].exp_rd;

        // Collision: a write and a register command arrive during a read.
        @(negedge clk); #1;
        MemIO = 2'b01; ALUAddr = 32'h300; mem_ready = 1'b0;
        @(negedge clk); #1;
        MemIO = 2'b10; ALUAddr = 32'h400; WrData = 32'h55;
        @(negedge clk);
        check("coll/dropped", 32'(CmdDropped), 1);
        #1 MemIO = 2'b11; WrData = 32'hAA;
        @(negedge clk);
        check("coll/gpr_we", 32'(GprWe), 1);
        check("coll/gpr_data", GprData, 32'hAA);
        check("coll/dropped_once", 32'(CmdDropped), 0);
        check("coll/still_req", 32'(mem_req), 1);
        #1 MemIO = 2'b00; mem_ready = 1'b1; mem_rdata = 32'h0BADBEEF;
        @(negedge clk);
        check("coll/valid", 32'(ValidMemData), 1);
        check("coll/rddata", RdData, 32'h0BADBEEF);
        check("coll/addr", mem_addr, 32'h300);
        check("coll/we", 32'(mem_we), 0);
        #1 mem_ready = 1'b0;
        model_rd = 32'h0BADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("coll/no_second", 32'(mem_req), 0);
        end

        // Random transactions with command noise while busy.
        for (int i = 0; i < 25; i++) begin
            logic        wr;
            logic [31:0] rdata;
            int          waits, exp_req;
            logic        exp_err;
            logic [31:0] exp_rd;
            wr      = 1'($urandom);
            rdata   = $urandom;
            waits   = $urandom_range(0, TIMEOUT + 1);
            exp_err = (waits + 1 > int'(TIMEOUT));
            exp_req = exp_err ? int'(TIMEOUT) : waits + 1;
            exp_rd  = exp_err ? 32'h0 : (wr ? model_rd : rdata);
            run_txn($sformatf("rnd%0d", i), wr, $urandom, $urandom, rdata, waits, 1'b1,
                    exp_req, exp_req + 1, exp_err, exp_rd);
            model_rd = exp_rd;
        end

        // Reset in the middle of a request.
        @(negedge clk); #1;
        MemIO = 2'b01; ALUAddr = 32'h700; mem_ready = 1'b0;
        @(negedge clk); #1 MemIO = 2'b00;
        @(negedge clk);
        check("rst/req_before", 32'(mem_req), 1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst/req_async", 32'(mem_req), 0);
        check("rst/busy_async", 32'(Busy), 0);
        check("rst/valid_async", 32'(ValidMemData), 0);
        @(negedge clk);
        check_all_zero("rst_held");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst/no_valid", 32'(ValidMemData), 0);
        end
        #1 chk_en = 1'b1;
        run_txn("post_rst", 1'b0, 32'h704, 32'h0, 32'h600DF00D, 1, 1'b0, 2, 3, 1'b0,
                32'h600DF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
